// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-point FFT datapath: serial load, pipeline wait, serial unload.
// Optional macro FFT16_BITREV_EN: unload capture slots in bit-reversed order (natural-order bins out).
module fft16_frame_ctrl #(
  parameter int DATA_WIDTH   = 20,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_real,
  input  logic [DATA_WIDTH-1:0]      s_imag,
  input  logic                       s_last,
  output logic [16*DATA_WIDTH-1:0]   dp_in_real,
  output logic [16*DATA_WIDTH-1:0]   dp_in_imag,
  input  logic [16*DATA_WIDTH-1:0]   dp_out_real,
  input  logic [16*DATA_WIDTH-1:0]   dp_out_imag,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_real,
  output logic [DATA_WIDTH-1:0]      m_imag,
  output logic [3:0]                 m_index,
  output logic                       m_last,
  output logic                       busy,
  output logic                       frame_err
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            wr_idx_q, wr_idx_d;
  logic [3:0]            rd_idx_q, rd_idx_d;
  logic [5:0]            wait_cnt_q, wait_cnt_d;
  logic                  frame_err_q, frame_err_d;
  logic [DATA_WIDTH-1:0] in_re_q  [16];
  logic [DATA_WIDTH-1:0] in_re_d  [16];
  logic [DATA_WIDTH-1:0] in_im_q  [16];
  logic [DATA_WIDTH-1:0] in_im_d  [16];
  logic [DATA_WIDTH-1:0] cap_re_q [16];
  logic [DATA_WIDTH-1:0] cap_re_d [16];
  logic [DATA_WIDTH-1:0] cap_im_q [16];
  logic [DATA_WIDTH-1:0] cap_im_d [16];
  logic                  s_xfer;
  logic                  m_xfer;
  logic [3:0]            rd_slot;

  function automatic logic [3:0] sel_slot(input logic [3:0] k);
`ifdef FFT16_BITREV_EN
    sel_slot = {k[0], k[1], k[2], k[3]};
`else
    sel_slot = k;
`endif
  endfunction

  // Sample i sits in the most-significant end for i = 0.
  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign dp_in_real[DATA_WIDTH*(16-g)-1 -: DATA_WIDTH] = in_re_q[g];
    assign dp_in_imag[DATA_WIDTH*(16-g)-1 -: DATA_WIDTH] = in_im_q[g];
  end

  // s_ready is gated by rst so it reads 0 during reset and 1 right after release.
  assign s_ready   = ~rst & (state_q == ST_LOAD);
  assign m_valid   = (state_q == ST_UNLOAD);
  assign busy      = (state_q == ST_WAIT) | (state_q == ST_UNLOAD);
  assign m_index   = rd_idx_q;
  assign m_last    = m_valid & (rd_idx_q == 4'd15);
  assign rd_slot   = sel_slot(rd_idx_q);
  assign m_real    = m_valid ? cap_re_q[rd_slot] : {DATA_WIDTH{1'b0}};
  assign m_imag    = m_valid ? cap_im_q[rd_slot] : {DATA_WIDTH{1'b0}};
  assign frame_err = frame_err_q;
  assign s_xfer    = s_valid & s_ready;
  assign m_xfer    = m_valid & m_ready;

  // Next-state, buffer writes and counters for the load/wait/unload sequence.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    wait_cnt_d  = wait_cnt_q;
    frame_err_d = 1'b0;
    in_re_d     = in_re_q;
    in_im_d     = in_im_q;
    cap_re_d    = cap_re_q;
    cap_im_d    = cap_im_q;

    case (state_q)
      ST_LOAD: begin
        if (s_xfer) begin
          in_re_d[wr_idx_q] = s_real;
          in_im_d[wr_idx_q] = s_imag;
          if (wr_idx_q == 4'd15) begin
            wr_idx_d   = 4'd0;
            wait_cnt_d = 6'(PIPE_LATENCY);
            state_d    = ST_WAIT;
          end else if (s_last) begin
            // Short frame: clear the unfilled tail so stale samples never reach the datapath.
            for (int i = 0; i < 16; i++) begin
              in_re_d[i] = (i > int'(wr_idx_q)) ? {DATA_WIDTH{1'b0}} : in_re_d[i];
              in_im_d[i] = (i > int'(wr_idx_q)) ? {DATA_WIDTH{1'b0}} : in_im_d[i];
            end
            frame_err_d = 1'b1;
            wr_idx_d    = 4'd0;
            wait_cnt_d  = 6'(PIPE_LATENCY);
            state_d     = ST_WAIT;
          end else begin
            wr_idx_d = wr_idx_q + 4'd1;
          end
        end else begin
          wr_idx_d = wr_idx_q;
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == 6'd0) begin
          for (int i = 0; i < 16; i++) begin
            cap_re_d[i] = dp_out_real[DATA_WIDTH*(16-i)-1 -: DATA_WIDTH];
            cap_im_d[i] = dp_out_imag[DATA_WIDTH*(16-i)-1 -: DATA_WIDTH];
          end
          rd_idx_d = 4'd0;
          state_d  = ST_UNLOAD;
        end else begin
          wait_cnt_d = wait_cnt_q - 6'd1;
        end
      end

      ST_UNLOAD: begin
        if (m_xfer) begin
          if (rd_idx_q == 4'd15) begin
            rd_idx_d = 4'd0;
            state_d  = ST_LOAD;
          end else begin
            rd_idx_d = rd_idx_q + 4'd1;
          end
        end else begin
          rd_idx_d = rd_idx_q;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State, counters and both frame buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      wr_idx_q    <= 4'd0;
      rd_idx_q    <= 4'd0;
      wait_cnt_q  <= 6'd0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        in_re_q[i]  <= {DATA_WIDTH{1'b0}};
        in_im_q[i]  <= {DATA_WIDTH{1'b0}};
        cap_re_q[i] <= {DATA_WIDTH{1'b0}};
        cap_im_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      frame_err_q <= frame_err_d;
      in_re_q     <= in_re_d;
      in_im_q     <= in_im_d;
      cap_re_q    <= cap_re_d;
      cap_im_q    <= cap_im_d;
    end
  end

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Bench for fft16_frame_ctrl: delay-line datapath stub, frame-level reference model, table + random frames.
module tb_fft16_frame_ctrl;
  localparam int DW = 20;
  localparam int P  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_real = '0;
  logic [DW-1:0]   s_imag = '0;
  logic            s_last = 1'b0;
  logic [16*DW-1:0] dp_in_real, dp_in_imag, dp_out_real, dp_out_imag;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [DW-1:0]   m_real, m_imag;
  logic [3:0]      m_index;
  logic            m_last, busy, frame_err;

  fft16_frame_ctrl #(.DATA_WIDTH(DW), .PIPE_LATENCY(P)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
    .dp_in_real(dp_in_real), .dp_in_imag(dp_in_imag),
    .dp_out_real(dp_out_real), .dp_out_imag(dp_out_imag),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Datapath stub: pure P-cycle delay line.
  logic [16*DW-1:0] dl_re [P];
  logic [16*DW-1:0] dl_im [P];
  always @(posedge clk) begin
    dl_re[0] <= dp_in_real;
    dl_im[0] <= dp_in_imag;
    for (int k = 1; k < P; k++) begin
      dl_re[k] <= dl_re[k-1];
      dl_im[k] <= dl_im[k-1];
    end
  end
  assign dp_out_real = dl_re[P-1];
  assign dp_out_imag = dl_im[P-1];

  int cyc = 0;
  int fe_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

  int n_checks = 0;
  int n_err = 0;
  int last_mlast_edge = 0;

  int            fr_len;
  logic [DW-1:0] fr_re [16];
  logic [DW-1:0] fr_im [16];
  logic [DW-1:0] ex_re [16];
  logic [DW-1:0] ex_im [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: cycle budget expired (t=%0t)", nm, $time);
  endtask

  function automatic int rev4(input int k);
    return ((k & 1) * 8) + ((k & 2) * 2) + ((k & 4) / 2) + ((k & 8) / 8);
  endfunction

  function automatic int selk(input int k);
`ifdef FFT16_BITREV_EN
    return rev4(k);
`else
    return k;
`endif
  endfunction

  // Reference: the datapath stub is identity, so bin k carries input slot sel(k), zero past a short frame.
  task automatic build_expect();
    for (int k = 0; k < 16; k++) begin
      int s;
      s = selk(k);
      ex_re[k] = (s < fr_len) ? fr_re[s] : '0;
      ex_im[k] = (s < fr_len) ? fr_im[s] : '0;
    end
  endtask

  task automatic make_frame(input int kind, input int len);
    fr_len = len;
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0: begin fr_re[i] = DW'(100 * i); fr_im[i] = DW'(-i); end
        1: begin fr_re[i] = DW'(i + 1);   fr_im[i] = '0;      end
        default: begin fr_re[i] = DW'($urandom); fr_im[i] = DW'($urandom); end
      endcase
    end
    build_expect();
  endtask

  // Drives one frame in and drains it; stop_k < 16 abandons the unload after stop_k transfers.
  task automatic run_frame(input int rdy, input bit hold, input bit b2b, input bit exp_err, input int stop_k);
    int i, k, e0, guard, ph, fe0;
    bit first_seen, gap;
    fe0 = fe_cnt; i = 0; e0 = 0; guard = 0;
    while (i < fr_len && guard < 300) begin
      gap = (rdy == 2) && !(b2b && i == 0) && ($urandom_range(0, 3) == 0);
      s_valid = !gap;
      s_real  = fr_re[i];
      s_imag  = fr_im[i];
      s_last  = (i == fr_len - 1);
      @(negedge clk);
      if (s_valid && s_ready) begin
        if (i == 0 && b2b) chk("b2b_first_xfer_edge", 64'(cyc + 1), 64'(last_mlast_edge + 1));
        if (i == fr_len - 1) e0 = cyc + 1;
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (i < fr_len) timeout("load");
    chk("frame_err_pulse", 64'(frame_err), 64'(exp_err));
    s_valid = hold;
    s_last  = 1'b0;
    s_real  = DW'($urandom);
    s_imag  = DW'($urandom);

    k = 0; guard = 0; ph = 0; first_seen = 0;
    while (k < stop_k && guard < 600) begin
      case (rdy)
        0:       m_ready = 1'b1;
        1:       m_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      chk("s_ready_low_busy", 64'(s_ready), 64'd0);
      chk("busy_high", 64'(busy), 64'd1);
      if (m_valid) begin
        if (!first_seen) chk("first_valid_edge", 64'(cyc), 64'(e0 + P + 1));
        first_seen = 1;
        chk("m_real", 64'(m_real), 64'(ex_re[k]));
        chk("m_imag", 64'(m_imag), 64'(ex_im[k]));
        chk("m_index", 64'(m_index), 64'(k));
        chk("m_last", 64'(m_last), 64'(k == 15));
        ph++;
        if (m_ready) begin
          if (k == 15) last_mlast_edge = cyc + 1;
          k++;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    if (k < stop_k) timeout("unload");
    if (!hold) s_valid = 1'b0;
    if (stop_k == 16) begin
      chk("m_valid_drop", 64'(m_valid), 64'd0);
      chk("s_ready_rise", 64'(s_ready), 64'd1);
      chk("busy_clear", 64'(busy), 64'd0);
      chk("frame_err_count", 64'(fe_cnt - fe0), 64'(exp_err));
    end
  endtask

  typedef struct {
    int kind;
    int len;
    int rdy;
    bit hold;
    bit b2b;
    bit exp_err;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{kind: 0, len: 16, rdy: 0, hold: 1'b0, b2b: 1'b0, exp_err: 1'b0};
    tbl[1] = '{kind: 1, len: 5,  rdy: 0, hold: 1'b0, b2b: 1'b0, exp_err: 1'b1};
    tbl[2] = '{kind: 2, len: 16, rdy: 1, hold: 1'b1, b2b: 1'b0, exp_err: 1'b0};
    tbl[3] = '{kind: 0, len: 16, rdy: 2, hold: 1'b1, b2b: 1'b1, exp_err: 1'b0};
    tbl[4] = '{kind: 2, len: 1,  rdy: 0, hold: 1'b0, b2b: 1'b1, exp_err: 1'b1};
    tbl[5] = '{kind: 2, len: 15, rdy: 1, hold: 1'b0, b2b: 1'b0, exp_err: 1'b1};
    tbl[6] = '{kind: 1, len: 16, rdy: 2, hold: 1'b0, b2b: 1'b0, exp_err: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_dp_in_zero", 64'(dp_in_real != '0), 64'd0);
    rst = 1'b0;
    #1;
    chk("s_ready_after_release", 64'(s_ready), 64'd1);

    for (int r = 0; r < 7; r++) begin
      make_frame(tbl[r].kind, tbl[r].len);
      run_frame(tbl[r].rdy, tbl[r].hold, tbl[r].b2b, tbl[r].exp_err, 16);
    end

    // Reset in the middle of an unload, at rd_idx = 7.
    make_frame(0, 16);
    run_frame(0, 1'b0, 1'b0, 1'b0, 7);
    m_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_m_real", 64'(m_real), 64'd0);
    chk("midrst_m_index", 64'(m_index), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_s_ready_release", 64'(s_ready), 64'd1);
    chk("midrst_no_output", 64'(m_valid), 64'd0);
    make_frame(2, 16);
    run_frame(0, 1'b0, 1'b0, 1'b0, 16);

    for (int r = 0; r < 6; r++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      make_frame(2, len);
      run_frame(2, 1'b0, 1'b0, len < 16, 16);
    end

    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
